// File: rtl/triangle_scan_gen.sv
// triangle_scan_gen
//   Captures one triangle (three unsigned integer vertices), computes its
//   axis-aligned bounding box and walks that box in row-major order, issuing
//   one candidate pixel per cycle in which downstream is ready. Each pixel is
//   presented as integer coordinates and as exact fp16 values for the area
//   units' p inputs.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active low
//   tri_nd         new triangle valid (sampled only while tri_rfd=1)
//   tri_rfd        ready for a new triangle (combinational)
//   v{0,1,2}_{x,y} unsigned vertex coordinates, COORD_W bits each
//   ds_rfd         downstream ready; a pixel issues only when this is 1
//   nd             pixel valid, one-cycle pulse per pixel
//   p_x, p_y       fp16 pixel coordinates
//   pix_x, pix_y   integer pixel coordinates (same pixel as p_x/p_y)
//   last           high with nd on the final pixel of the triangle
//   busy           high while computing the box or scanning
module triangle_scan_gen #(
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tri_nd,
  output logic               tri_rfd,
  input  logic [COORD_W-1:0] v0_x,
  input  logic [COORD_W-1:0] v0_y,
  input  logic [COORD_W-1:0] v1_x,
  input  logic [COORD_W-1:0] v1_y,
  input  logic [COORD_W-1:0] v2_x,
  input  logic [COORD_W-1:0] v2_y,
  input  logic               ds_rfd,
  output logic               nd,
  output logic [15:0]        p_x,
  output logic [15:0]        p_y,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               last,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BBOX = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic [COORD_W-1:0] ZERO = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] ONE  = {{(COORD_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  logic [COORD_W-1:0] c0_x_r, c0_y_r, c1_x_r, c1_y_r, c2_x_r, c2_y_r;
  logic [COORD_W-1:0] min_x_r, max_x_r, min_y_r, max_y_r;
  logic [COORD_W-1:0] cur_x_r, cur_y_r;
  logic               end_x_s, end_y_s;

  function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                              input logic [COORD_W-1:0] b,
                                              input logic [COORD_W-1:0] c);
    logic [COORD_W-1:0] t;
    t = (a < b) ? a : b;
    return (t < c) ? t : c;
  endfunction

  function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                              input logic [COORD_W-1:0] b,
                                              input logic [COORD_W-1:0] c);
    logic [COORD_W-1:0] t;
    t = (a > b) ? a : b;
    return (t > c) ? t : c;
  endfunction

  // Exact unsigned-int to fp16: exponent 15+msb index, the bits below the
  // MSB left-aligned into the 10-bit mantissa. COORD_W<=11 keeps it exact.
  function automatic logic [15:0] to_fp16(input logic [COORD_W-1:0] n);
    logic [10:0] v;
    logic [10:0] sh;
    logic [3:0]  m;
    logic [4:0]  e;
    v = 11'(n);
    m = 4'd0;
    for (int i = 0; i < 11; i++) begin
      if (v[i]) begin
        m = 4'(i);
      end else begin
        m = m;
      end
    end
    sh = v << (4'd10 - m);
    e  = 5'd15 + {1'b0, m};
    if (v == 11'd0) begin
      return 16'h0000;
    end else begin
      return {1'b0, e, sh[9:0]};
    end
  endfunction

  // Cursor position relative to the far edges of the box
  always_comb begin
    end_x_s = (cur_x_r == max_x_r);
    end_y_s = (cur_y_r == max_y_r);
  end

  assign tri_rfd = (state_r == IDLE) & rst;

  // Control FSM, bounding box, cursor and registered pixel outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      nd      <= 1'b0;
      last    <= 1'b0;
      busy    <= 1'b0;
      p_x     <= 16'h0000;
      p_y     <= 16'h0000;
      pix_x   <= ZERO;
      pix_y   <= ZERO;
      c0_x_r  <= ZERO;
      c0_y_r  <= ZERO;
      c1_x_r  <= ZERO;
      c1_y_r  <= ZERO;
      c2_x_r  <= ZERO;
      c2_y_r  <= ZERO;
      min_x_r <= ZERO;
      max_x_r <= ZERO;
      min_y_r <= ZERO;
      max_y_r <= ZERO;
      cur_x_r <= ZERO;
      cur_y_r <= ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          nd   <= 1'b0;
          last <= 1'b0;
          if (tri_nd) begin
            c0_x_r  <= v0_x;
            c0_y_r  <= v0_y;
            c1_x_r  <= v1_x;
            c1_y_r  <= v1_y;
            c2_x_r  <= v2_x;
            c2_y_r  <= v2_y;
            busy    <= 1'b1;
            state_r <= BBOX;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        BBOX: begin
          min_x_r <= min3(c0_x_r, c1_x_r, c2_x_r);
          max_x_r <= max3(c0_x_r, c1_x_r, c2_x_r);
          min_y_r <= min3(c0_y_r, c1_y_r, c2_y_r);
          max_y_r <= max3(c0_y_r, c1_y_r, c2_y_r);
          cur_x_r <= min3(c0_x_r, c1_x_r, c2_x_r);
          cur_y_r <= min3(c0_y_r, c1_y_r, c2_y_r);
          state_r <= SCAN;
        end
        SCAN: begin
          if (ds_rfd) begin
            nd    <= 1'b1;
            pix_x <= cur_x_r;
            pix_y <= cur_y_r;
            p_x   <= to_fp16(cur_x_r);
            p_y   <= to_fp16(cur_y_r);
            last  <= end_x_s & end_y_s;
            // The cursor is not advanced past the final pixel, so no wrap
            // occurs even when max is 2^COORD_W-1.
            if (end_x_s && end_y_s) begin
              busy    <= 1'b0;
              state_r <= IDLE;
            end else if (end_x_s) begin
              cur_x_r <= min_x_r;
              cur_y_r <= cur_y_r + ONE;
            end else begin
              cur_x_r <= cur_x_r + ONE;
            end
          end else begin
            nd   <= 1'b0;
            last <= 1'b0;
          end
        end
        default: begin
          nd      <= 1'b0;
          last    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_scan_gen.sv
module tb_triangle_scan_gen;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tri_nd = 1'b0;
  logic         ds_rfd = 1'b0;
  logic [W-1:0] v0_x = '0, v0_y = '0, v1_x = '0, v1_y = '0, v2_x = '0, v2_y = '0;
  logic         tri_rfd, nd, last, busy;
  logic [15:0]  p_x, p_y;
  logic [W-1:0] pix_x, pix_y;

  int errors = 0;
  int checks = 0;

  triangle_scan_gen #(.COORD_W(W)) dut (
    .clk(clk), .rst(rst), .tri_nd(tri_nd), .tri_rfd(tri_rfd),
    .v0_x(v0_x), .v0_y(v0_y), .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y),
    .ds_rfd(ds_rfd), .nd(nd), .p_x(p_x), .p_y(p_y), .pix_x(pix_x), .pix_y(pix_y),
    .last(last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference fp16 from the numeric definition: value = 2^m * (1 + mant/1024)
  function automatic logic [15:0] ref_fp16(input int n);
    int m;
    int mant;
    if (n == 0) return 16'h0000;
    m = 0;
    while ((1 << (m + 1)) <= n) m++;
    mant = (n - (1 << m)) * (1 << (10 - m));
    return 16'(((15 + m) << 10) + mant);
  endfunction

  task automatic scramble_vertices();
    v0_x = W'($urandom); v0_y = W'($urandom); v1_x = W'($urandom);
    v1_y = W'($urandom); v2_x = W'($urandom); v2_y = W'($urandom);
  endtask

  // mode 0: ds_rfd always 1; 1: pattern 1,0,0 repeating; 2: random.
  // inject: offer other triangles while busy. abort_after>0: reset after that many pixels.
  task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy, input int mode,
                         input bit inject, input int abort_after);
    int qx[$];
    int qy[$];
    int xs[$];
    int ys[$];
    int mnx, mxx, mny, mxy;
    int lx, ly, issued, budget, k;
    bit ds;
    xs = '{ax, bx, cx};
    ys = '{ay, by, cy};
    mnx = xs.min()[0]; mxx = xs.max()[0];
    mny = ys.min()[0]; mxy = ys.max()[0];
    for (int y = mny; y <= mxy; y++)
      for (int x = mnx; x <= mxx; x++) begin
        qx.push_back(x);
        qy.push_back(y);
      end
    lx = -1; ly = -1; issued = 0; budget = 0; k = 0;

    while (tri_rfd !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk("rfd_before_capture", 32'(tri_rfd), 32'd1);
    v0_x = W'(ax); v0_y = W'(ay); v1_x = W'(bx); v1_y = W'(by); v2_x = W'(cx); v2_y = W'(cy);
    tri_nd = 1'b1;
    ds_rfd = 1'($urandom_range(0, 1));
    @(negedge clk);
    tri_nd = 1'b0;
    scramble_vertices();
    chk("busy_after_capture", 32'(busy), 32'd1);
    chk("rfd_low_when_busy", 32'(tri_rfd), 32'd0);
    ds_rfd = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("nd_in_bbox", 32'(nd), 32'd0);

    budget = 0;
    while (qx.size() > 0 && budget < 400) begin
      case (mode)
        0:       ds = 1'b1;
        1:       ds = (k % 3 == 0);
        default: ds = 1'($urandom_range(0, 1));
      endcase
      k++;
      ds_rfd = ds;
      if (inject) begin
        tri_nd = 1'($urandom_range(0, 1));
        scramble_vertices();
      end
      @(negedge clk);
      budget++;
      if (ds) begin
        chk("nd_issue", 32'(nd), 32'd1);
        chk("pix_x", 32'(pix_x), 32'(qx[0]));
        chk("pix_y", 32'(pix_y), 32'(qy[0]));
        chk("p_x", 32'(p_x), 32'(ref_fp16(qx[0])));
        chk("p_y", 32'(p_y), 32'(ref_fp16(qy[0])));
        chk("last", 32'(last), 32'(qx.size() == 1));
        lx = qx.pop_front();
        ly = qy.pop_front();
        issued++;
        chk("busy_scan", 32'(busy), 32'(qx.size() > 0));
        if (abort_after > 0 && issued == abort_after) begin
          rst = 1'b0;
          tri_nd = 1'b0;
          ds_rfd = 1'b1;
          @(negedge clk);
          chk("abort_nd", 32'(nd), 32'd0);
          chk("abort_busy", 32'(busy), 32'd0);
          chk("abort_pix_x", 32'(pix_x), 32'd0);
          chk("abort_p_y", 32'(p_y), 32'd0);
          chk("abort_rfd", 32'(tri_rfd), 32'd0);
          rst = 1'b1;
          for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_nd", 32'(nd), 32'd0);
          end
          return;
        end
      end else begin
        chk("nd_stall", 32'(nd), 32'd0);
        chk("last_stall", 32'(last), 32'd0);
        chk("busy_stall", 32'(busy), 32'd1);
        if (lx >= 0) begin
          chk("hold_pix_x", 32'(pix_x), 32'(lx));
          chk("hold_pix_y", 32'(pix_y), 32'(ly));
          chk("hold_p_x", 32'(p_x), 32'(ref_fp16(lx)));
        end
      end
    end
    tri_nd = 1'b0;
    ds_rfd = 1'($urandom_range(0, 1));
    chk("all_pixels_issued", 32'(qx.size()), 32'd0);
    chk("rfd_after_last", 32'(tri_rfd), 32'd1);
    chk("busy_after_last", 32'(busy), 32'd0);
    @(negedge clk);
    chk("nd_after_last", 32'(nd), 32'd0);
  endtask

  initial begin
    int bx, by;
    // Reset held for 3 cycles while a triangle is offered
    rst = 1'b0;
    tri_nd = 1'b1;
    v0_x = 10'd7; v0_y = 10'd7; v1_x = 10'd9; v1_y = 10'd9; v2_x = 10'd8; v2_y = 10'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_nd", 32'(nd), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rfd", 32'(tri_rfd), 32'd0);
      chk("rst_p_x", 32'(p_x), 32'd0);
      chk("rst_pix_y", 32'(pix_y), 32'd0);
    end
    rst = 1'b1;
    tri_nd = 1'b0;
    @(negedge clk);
    chk("rfd_after_release", 32'(tri_rfd), 32'd1);
    chk("busy_after_release", 32'(busy), 32'd0);

    // Basic six-pixel triangle, no stalls
    run_tri(2, 1, 4, 1, 3, 2, 0, 1'b0, 0);
    // fp16 corner values and one-point boxes
    run_tri(1023, 640, 1023, 640, 1023, 640, 0, 1'b0, 0);
    run_tri(0, 0, 0, 0, 0, 0, 0, 1'b0, 0);
    // Backpressure pattern 1,0,0
    run_tri(2, 1, 4, 1, 3, 2, 1, 1'b0, 0);
    // Triangles offered while busy must be ignored
    run_tri(2, 1, 4, 1, 3, 2, 2, 1'b1, 0);
    // Reset after the 3rd pixel of a 9-pixel box, then a fresh triangle
    run_tri(0, 0, 2, 2, 0, 2, 0, 1'b0, 3);
    run_tri(5, 3, 6, 4, 5, 4, 0, 1'b0, 0);
    // Box touching the top of the coordinate range
    run_tri(1020, 1021, 1023, 1023, 1021, 1020, 2, 1'b0, 0);
    // Random small triangles with random backpressure
    for (int t = 0; t < 8; t++) begin
      bx = $urandom_range(0, 1015);
      by = $urandom_range(0, 1015);
      run_tri(bx + $urandom_range(0, 7), by + $urandom_range(0, 7),
              bx + $urandom_range(0, 7), by + $urandom_range(0, 7),
              bx + $urandom_range(0, 7), by + $urandom_range(0, 7),
              2, t[0], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/triangle_scan_gen.md
Name: triangle_scan_gen

Overview:
- Upstream feeder for the per-edge triangle area units in the pixel pipeline's triangle rasterizer.
- Accepts one triangle as three integer screen-space vertices and computes its axis-aligned bounding box.
- Walks the box in row-major order, emitting one candidate pixel per accepted cycle.
- Each pixel is presented both as integer coordinates and as IEEE-754 half-precision (fp16) p_x/p_y, ready to drive an area unit's p inputs and nd.

Parameters:
COORD_W, 10, width of unsigned integer screen coordinates; legal range 1..11 so that int-to-fp16 conversion is exact.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
tri_nd  in  1  new triangle valid; sampled only while tri_rfd=1
tri_rfd  out  1  ready for a new triangle
v0_x, v0_y, v1_x, v1_y, v2_x, v2_y  in  COORD_W each  unsigned vertex coordinates
ds_rfd  in  1  downstream ready; a pixel is issued only in a cycle where this is 1
nd  out  1  pixel valid, one-cycle pulse per pixel
p_x, p_y  out  16  fp16 pixel coordinates
pix_x, pix_y  out  COORD_W  integer pixel coordinates, same pixel as p_x/p_y
last  out  1  high with nd on the final pixel of the triangle
busy  out  1  high in BBOX or SCAN

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - nd, last, busy = 0; p_x, p_y, pix_x, pix_y = 0.
  - A reset mid-scan abandons the triangle; no further pixels are emitted.
- States:
  - IDLE: tri_rfd=1. When tri_nd=1, capture the six vertex inputs and go to BBOX. tri_nd is ignored in every other state.
  - BBOX (exactly 1 cycle):
    - min_x/max_x/min_y/max_y = unsigned min/max of the three vertices.
    - cur_x=min_x, cur_y=min_y.
    - Go to SCAN.
  - SCAN, on each edge with ds_rfd=1:
    - Register nd=1, pix_x=cur_x, pix_y=cur_y, p_x=fp16(cur_x), p_y=fp16(cur_y), last=(cur_x==max_x && cur_y==max_y).
    - Advance: if cur_x==max_x then cur_x=min_x, cur_y=cur_y+1; else cur_x=cur_x+1.
    - After issuing the last pixel, go to IDLE.
  - SCAN, on each edge with ds_rfd=0: nd=0, last=0, coordinates held, cursor held.
- tri_rfd is combinational: (state==IDLE) & rst.
- Latency: first nd appears at the earliest 2 edges after the tri_nd edge (capture edge, BBOX edge, first issue edge).
- Next triangle: can be captured on the edge after last is issued (IDLE for 1 cycle).
- nd is high in at most one cycle per pixel.
- Pixel count per triangle is (max_x-min_x+1)*(max_y-min_y+1). Degenerate triangles (collinear or coincident vertices) are still scanned; one-point box gives exactly 1 pixel with last=1.
- No wrap-around: the cursor never exceeds max_x/max_y, and max values ≤ 2^COORD_W-1, so max coordinate 2^COORD_W-1 is scanned correctly.
- fp16(n) conversion, combinational, exact:
  - n=0 gives 16'h0000.
  - Otherwise, with m = index of the MSB set: sign=0, exponent=15+m, mantissa = the bits below the MSB, left-aligned into 10 bits with zero fill.
- Vertex inputs may change freely after the capture edge.

Test Plan:
- Reset: hold rst=0 for 3 cycles with tri_nd=1 -> nd=0, busy=0, tri_rfd=0 during reset; tri_rfd=1 first cycle after release.
- Single triangle, ds_rfd=1 constantly, v0=(2,1), v1=(4,1), v2=(3,2) -> 6 pixels in order (2,1),(3,1),(4,1),(2,2),(3,2),(4,2) on consecutive cycles; p_x of first = 16'h4000; p_x=3 gives 16'h4200; last only on (4,2); then tri_rfd=1.
- fp16 check: triangle with all vertices at (1023,640) -> exactly 1 pixel, p_x=16'h63FE, p_y=16'h6100, last=1; all vertices at (0,0) -> p_x=p_y=16'h0000.
- Backpressure: same 6-pixel triangle with ds_rfd toggling 1,0,0,1,… -> nd only in cycles following ds_rfd=1 edges; sequence and count unchanged; outputs held while stalled.
- Busy rejection: assert tri_nd with different vertices during SCAN -> ignored; the original triangle's pixels complete unchanged.
- Reset mid-op: pull rst=0 after the 3rd pixel of a 9-pixel box (v=(0,0),(2,2),(0,2)) -> no further nd; next triangle scans from its own min corner.
